// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared register map, width helper and FIFO entry type for multi_port_router
package router_pkg;

  localparam logic [3:0] ADDR_CTRL         = 4'h0;
  localparam logic [3:0] ADDR_OUT_MASK     = 4'h1;
  localparam logic [3:0] ADDR_DROP_CNT     = 4'h2;
  localparam logic [3:0] ADDR_STATUS       = 4'h3;
  localparam logic [3:0] ADDR_PKT_CNT_BASE = 4'h8;

  localparam int CTRL_EN = 0;

  // Never returns 0 so single-entry ranges still get a 1-bit field
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Entry layout for the default 4-output, 8-bit build; the router overrides it per parameter set
  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-input show-ahead FIFO, full/empty from pointers carrying an extra wrap bit
module router_fifo
  import router_pkg::*;
#(
  parameter type entry_t = fifo_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t din_i,
  input  logic   pop_i,
  output entry_t dout_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  entry_t          mem_q [DEPTH];
  logic   [PW:0]   wr_ptr_q;
  logic   [PW:0]   rd_ptr_q;
  logic   [PW:0]   wr_ptr_d;
  logic   [PW:0]   rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

  assign wr_ptr_d = (push_i && !full_o)  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = (pop_i  && !empty_o) ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/multi_port_router.sv
// rtl/multi_port_router.sv - NUM_IN x NUM_OUT router, per-output round-robin; ROUTER_STATS_EN builds counters
module multi_port_router
  import router_pkg::*;
#(
  parameter  int NUM_IN     = 2,
  parameter  int NUM_OUT    = 4,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int REG_W      = 32,
  localparam int AW         = addr_w(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                reg_addr,
  input  logic [REG_W-1:0]          reg_wdata,
  input  logic                      reg_en,
  input  logic                      reg_we,
  output logic [REG_W-1:0]          reg_rdata,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN*AW-1:0]      in_addr,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready
);

  localparam int IW = addr_w(NUM_IN);

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                      en_q;
  logic [NUM_OUT-1:0]        mask_q;
  logic [REG_W-1:0]          rdata_q;
  logic [REG_W-1:0]          rdata_d;
  logic [NUM_OUT-1:0]        out_valid_q;
  logic [NUM_OUT*DATA_W-1:0] out_data_q;
  logic [NUM_OUT*DATA_W-1:0] out_data_d;
  logic [IW-1:0]             ptr_q [NUM_OUT];
  logic [IW-1:0]             ptr_d [NUM_OUT];
  logic [NUM_OUT-1:0]        load;
  entry_t                    din  [NUM_IN];
  entry_t                    head [NUM_IN];
  logic [NUM_IN-1:0]         full, empty, push, pop, drop, dest_ok;
  logic                      reg_wr;
  logic                      unused_wdata;

  assign in_ready     = ~full & {NUM_IN{en_q & ~rst}};
  assign push         = in_valid & in_ready;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign reg_rdata    = rdata_q;
  assign reg_wr       = reg_en && reg_we;
  assign unused_wdata = ^reg_wdata;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign din[i] = '{addr: in_addr[i*AW +: AW], data: in_data[i*DATA_W +: DATA_W]};
    router_fifo #(.entry_t(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[i]),
      .din_i  (din[i]),
      .pop_i  (pop[i]),
      .dout_o (head[i]),
      .full_o (full[i]),
      .empty_o(empty[i])
    );
  end

  // Heads whose destination is masked (or out of range) are discarded without arbitration
  always_comb begin
    dest_ok = '0;
    drop    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (head[i].addr == AW'(k) && mask_q[k]) dest_ok[i] = 1'b1;
      end
      drop[i] = en_q && !empty[i] && !dest_ok[i];
    end
  end

  always_comb begin
    int idx;
    idx        = 0;
    load       = '0;
    out_data_d = out_data_q;
    pop        = drop;
    for (int k = 0; k < NUM_OUT; k++) begin
      ptr_d[k] = ptr_q[k];
      if (en_q && mask_q[k] && (!out_valid_q[k] || out_ready[k])) begin
        for (int off = 0; off < NUM_IN; off++) begin
          idx = (int'(ptr_q[k]) + off) % NUM_IN;
          if (!load[k] && !empty[idx] && head[idx].addr == AW'(k)) begin
            load[k]                          = 1'b1;
            pop[idx]                         = 1'b1;
            out_data_d[k*DATA_W +: DATA_W]   = head[idx].data;
            ptr_d[k]                         = IW'((idx + 1) % NUM_IN);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      for (int k = 0; k < NUM_OUT; k++) ptr_q[k] <= '0;
    end else begin
      out_data_q <= out_data_d;
      for (int k = 0; k < NUM_OUT; k++) begin
        ptr_q[k] <= ptr_d[k];
        if (load[k])           out_valid_q[k] <= 1'b1;
        else if (out_ready[k]) out_valid_q[k] <= 1'b0;
      end
    end
  end

`ifdef ROUTER_STATS_EN
  logic [REG_W-1:0] drop_cnt_q;
  logic [REG_W-1:0] pkt_cnt_q [NUM_OUT];

  // A clearing write beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) pkt_cnt_q[k] <= '0;
    end else begin
      if (reg_wr && reg_addr == ADDR_DROP_CNT) drop_cnt_q <= '0;
      else                                     drop_cnt_q <= drop_cnt_q + REG_W'($countones(drop));
      for (int k = 0; k < NUM_OUT; k++) begin
        if (reg_wr && reg_addr == ADDR_PKT_CNT_BASE + 4'(k)) pkt_cnt_q[k] <= '0;
        else if (out_valid_q[k] && out_ready[k])             pkt_cnt_q[k] <= pkt_cnt_q[k] + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      ADDR_CTRL:     rdata_d[CTRL_EN]       = en_q;
      ADDR_OUT_MASK: rdata_d[NUM_OUT-1:0]   = mask_q;
      ADDR_STATUS:   rdata_d[NUM_IN-1:0]    = ~empty;
      default:       ;
    endcase
`ifdef ROUTER_STATS_EN
    if (reg_addr == ADDR_DROP_CNT) rdata_d = drop_cnt_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (reg_addr == ADDR_PKT_CNT_BASE + 4'(k)) rdata_d = pkt_cnt_q[k];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b1;
      mask_q  <= '1;
      rdata_q <= '0;
    end else begin
      if (reg_wr && reg_addr == ADDR_CTRL)     en_q   <= reg_wdata[CTRL_EN];
      if (reg_wr && reg_addr == ADDR_OUT_MASK) mask_q <= reg_wdata[NUM_OUT-1:0];
      if (reg_en && !reg_we)                   rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_multi_port_router.sv
// tb/tb_multi_port_router.sv - directed self-checking bench for multi_port_router
module tb_multi_port_router;

`ifdef ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_en;
  logic        reg_we;
  logic [31:0] reg_rdata;
  logic [15:0] in_data;
  logic [3:0]  in_addr;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;
  logic [7:0]  exp_seq [6];

  multi_port_router dut (
    .clk      (clk),
    .rst      (rst),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_en   (reg_en),
    .reg_we   (reg_we),
    .reg_rdata(reg_rdata),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_en = 1'b1; reg_we = 1'b1;
    tick();
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a; reg_en = 1'b1; reg_we = 1'b0;
    tick();
    reg_en = 1'b0;
    d = reg_rdata;
  endtask

  initial begin
    rst = 1'b1; reg_addr = '0; reg_wdata = '0; reg_en = 1'b0; reg_we = 1'b0;
    in_data = '0; in_addr = '0; in_valid = '0; out_ready = 4'hF;
    #1;
    tick();
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_rdata",     reg_rdata,      32'h0);
    tick();
    rst = 1'b0;
    reg_read(4'h0, rd); check("rst_ctrl", rd, 32'h1);
    reg_read(4'h1, rd); check("rst_mask", rd, 32'hF);
    reg_read(4'h3, rd); check("rst_status", rd, 32'h0);
    reg_read(4'h2, rd); check("rst_drop_cnt", rd, 32'h0);

    // Single beat, port 0 -> output 2
    in_data[7:0] = 8'hA5; in_addr[1:0] = 2'd2; in_valid = 2'b01;
    check("a_in_ready", 32'(in_ready), 32'h3);
    tick();
    in_valid = 2'b00;
    check("a_not_yet", 32'(out_valid), 32'h0);
    tick();
    check("a_out_valid", 32'(out_valid), 32'h4);
    check("a_out_data", 32'(out_data[23:16]), 32'hA5);
    tick();
    check("a_drained", 32'(out_valid), 32'h0);
    reg_read(4'hA, rd); check("a_pkt_cnt2", rd, STATS ? 32'd1 : 32'd0);

    // Two inputs to output 1: round-robin alternation
    out_ready = 4'b1101;
    in_addr = {2'd1, 2'd1}; in_valid = 2'b11;
    in_data = {8'h21, 8'h11}; tick();
    in_data = {8'h22, 8'h12}; tick();
    in_data = {8'h23, 8'h13}; tick();
    in_valid = 2'b00;
    check("rr_held_valid", 32'(out_valid), 32'h2);
    out_ready = 4'hF;
    exp_seq = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    for (int j = 0; j < 6; j++) begin
      check($sformatf("rr_valid_%0d", j), 32'(out_valid[1]), 32'h1);
      check($sformatf("rr_data_%0d", j), 32'(out_data[15:8]), 32'(exp_seq[j]));
      tick();
    end
    check("rr_idle", 32'(out_valid), 32'h0);
    reg_read(4'h9, rd); check("rr_pkt_cnt1", rd, STATS ? 32'd6 : 32'd0);

    // Backpressure on output 3: five beats fit, sixth is refused
    out_ready = 4'b0111;
    in_addr[1:0] = 2'd3; in_valid = 2'b01;
    for (int n = 0; n < 5; n++) begin
      in_data[7:0] = 8'h31 + 8'(n);
      check($sformatf("bp_ready_%0d", n), 32'(in_ready[0]), 32'h1);
      tick();
    end
    in_data[7:0] = 8'h36;
    check("bp_full", 32'(in_ready[0]), 32'h0);
    in_valid = 2'b00;
    reg_read(4'h3, rd); check("bp_status", rd, 32'h1);
    check("bp_held", 32'(out_data[31:24]), 32'h31);
    out_ready = 4'hF;
    for (int n = 0; n < 5; n++) begin
      check($sformatf("bp_drain_%0d", n), 32'(out_data[31:24]), 32'h31 + 32'(n));
      tick();
    end
    check("bp_idle", 32'(out_valid), 32'h0);

    // Masked output 2: beat is dropped and counted
    reg_write(4'h1, 32'hB);
    in_data[7:0] = 8'h77; in_addr[1:0] = 2'd2; in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    tick(); tick();
    check("mask_no_valid", 32'(out_valid), 32'h0);
    reg_read(4'h3, rd); check("mask_status", rd, 32'h0);
    reg_read(4'h2, rd); check("mask_drop_cnt", rd, STATS ? 32'd1 : 32'd0);
    reg_write(4'h2, 32'hFFFF);
    reg_read(4'h2, rd); check("mask_drop_clr", rd, 32'h0);
    reg_write(4'h1, 32'hF);

    // Disable while output 0 holds a beat
    out_ready = 4'b1110;
    in_data[15:8] = 8'h5A; in_addr[3:2] = 2'd0; in_valid = 2'b10;
    tick();
    in_data[15:8] = 8'h5B;
    tick();
    in_valid = 2'b00;
    reg_write(4'h0, 32'h0);
    check("dis_in_ready", 32'(in_ready), 32'h0);
    check("dis_held", 32'(out_valid), 32'h1);
    check("dis_held_data", 32'(out_data[7:0]), 32'h5A);
    out_ready = 4'hF;
    tick();
    check("dis_drained", 32'(out_valid), 32'h0);
    tick();
    check("dis_no_grant", 32'(out_valid), 32'h0);
    reg_read(4'h3, rd); check("dis_status", rd, 32'h2);
    reg_write(4'h0, 32'h1);
    tick();
    check("en_resume", 32'(out_valid), 32'h1);
    check("en_resume_data", 32'(out_data[7:0]), 32'h5B);

    // Asynchronous reset in the middle of traffic
    in_data[7:0] = 8'h99; in_addr[1:0] = 2'd1; in_valid = 2'b01;
    tick(); tick();
    check("mid_valid", 32'(out_valid[1]), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    in_valid = 2'b00;
    tick();
    rst = 1'b0;
    reg_read(4'h0, rd); check("post_ctrl", rd, 32'h1);
    reg_read(4'h1, rd); check("post_mask", rd, 32'hF);
    reg_read(4'h2, rd); check("post_drop", rd, 32'h0);
    reg_read(4'h9, rd); check("post_pkt1", rd, 32'h0);
    reg_read(4'h3, rd); check("post_status", rd, 32'h0);
    check("post_out_valid", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
